// File: rtl/serial_loader.sv
// serial_loader: receives a length-prefixed byte stream from the UART
// receiver, packs it big-endian into 32-bit words and writes it to RAM
// starting at BASE_ADDR. Reports success (PPC_EXEC) or failure (PPC_FAIL)
// on next_state.
// Optional feature: define SERIAL_LOADER_CHECKSUM_EN to expect and verify a
// trailing 8-bit additive checksum byte after the payload.

`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 12
`endif
`ifndef PPC_LOAD
`define PPC_LOAD 2'd1
`endif
`ifndef PPC_EXEC
`define PPC_EXEC 2'd2
`endif
`ifndef PPC_FAIL
`define PPC_FAIL 2'd3
`endif

module serial_loader #(
  parameter int ADDR_BITS      = `RAM_ADDR_BITS,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_ready,
  input  logic [7:0]           rx_data,
  output logic [1:0]           next_state,
  output logic [5:0]           leds,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [3:0]           ram_byteen,
  output logic [31:0]          ram_wrdata,
  output logic                 ram_rden,
  output logic                 ram_wren
);

  // Largest image (in bytes) that fits between BASE_ADDR and the top of RAM.
  localparam logic [63:0] MAX_BYTES =
      (64'd4 << ADDR_BITS) - (64'd4 * 64'(BASE_ADDR));
  localparam logic [31:0]          TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);
  localparam logic [ADDR_BITS-1:0] BASE_W        = ADDR_BITS'(BASE_ADDR);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_SUM,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           hdr_cnt_q, hdr_cnt_d;
  logic [31:0]          len_q, len_d;
  logic [31:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]          shift_q, shift_d;
  logic [31:0]          idle_q, idle_d;
  logic [1:0]           next_state_q, next_state_d;
  logic [5:0]           leds_q, leds_d;
  logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]           ram_byteen_q, ram_byteen_d;
  logic [31:0]          ram_wrdata_q, ram_wrdata_d;
  logic                 ram_wren_q, ram_wren_d;
`ifdef SERIAL_LOADER_CHECKSUM_EN
  logic [7:0]           sum_q, sum_d;
`endif

  logic [1:0] byte_pos;
  logic       byte_in;
  logic       counting;

  // Next-state logic: header collection, payload packing, checksum, timeout.
  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    idle_d       = idle_q;
    ram_addr_d   = ram_addr_q;
    ram_byteen_d = ram_byteen_q;
    ram_wrdata_d = ram_wrdata_q;
    ram_wren_d   = 1'b0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    byte_pos = byte_cnt_q[1:0];
    byte_in  = rx_ready && (state_q == ST_HDR || state_q == ST_DATA ||
                            state_q == ST_SUM);
    counting = (state_q == ST_DATA) || (state_q == ST_SUM) ||
               (state_q == ST_HDR && hdr_cnt_q != 2'd0);

    if (byte_in) begin
      idle_d = '0;
    end else if (counting) begin
      idle_d = idle_q + 32'd1;
    end

    case (state_q)
      ST_HDR: begin
        if (rx_ready) begin
          len_d     = {len_q[23:0], rx_data};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if ({32'd0, len_d} > MAX_BYTES) begin
              state_d = ST_ERR;
            end else if (len_d == 32'd0) begin
`ifdef SERIAL_LOADER_CHECKSUM_EN
              state_d = ST_SUM;
`else
              state_d = ST_DONE;
`endif
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (rx_ready) begin
          byte_cnt_d = byte_cnt_q + 32'd1;
`ifdef SERIAL_LOADER_CHECKSUM_EN
          sum_d      = sum_q + rx_data;
`endif
          if (byte_pos == 2'd0) begin
            shift_d = {rx_data, 24'd0};
          end else begin
            shift_d = shift_q | ({24'd0, rx_data} << {~byte_pos, 3'b000});
          end
          if (byte_pos == 2'd3 || byte_cnt_d == len_q) begin
            ram_wren_d   = 1'b1;
            ram_addr_d   = BASE_W + byte_cnt_q[ADDR_BITS+1:2];
            ram_byteen_d = ~(4'b0111 >> byte_pos);
            ram_wrdata_d = shift_d;
          end
          if (byte_cnt_d == len_q) begin
`ifdef SERIAL_LOADER_CHECKSUM_EN
            state_d = ST_SUM;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_SUM: begin
`ifdef SERIAL_LOADER_CHECKSUM_EN
        if (rx_ready) begin
          state_d = (rx_data == sum_q) ? ST_DONE : ST_ERR;
        end
`endif
      end
      default: begin
      end
    endcase

    if (counting && !byte_in && idle_d == TIMEOUT_LIMIT) begin
      state_d = ST_ERR;
    end

    case (state_d)
      ST_DONE: next_state_d = `PPC_EXEC;
      ST_ERR:  next_state_d = `PPC_FAIL;
      default: next_state_d = `PPC_LOAD;
    endcase
    leds_d = {state_d == ST_ERR, state_d == ST_DONE, byte_cnt_d[13:10]};
  end

  // State and registered outputs; reset clears everything including any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HDR;
      hdr_cnt_q    <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      idle_q       <= '0;
      next_state_q <= `PPC_LOAD;
      leds_q       <= '0;
      ram_addr_q   <= '0;
      ram_byteen_q <= '0;
      ram_wrdata_q <= '0;
      ram_wren_q   <= 1'b0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      idle_q       <= idle_d;
      next_state_q <= next_state_d;
      leds_q       <= leds_d;
      ram_addr_q   <= ram_addr_d;
      ram_byteen_q <= ram_byteen_d;
      ram_wrdata_q <= ram_wrdata_d;
      ram_wren_q   <= ram_wren_d;
`ifdef SERIAL_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign next_state = next_state_q;
  assign leds       = leds_q;
  assign ram_addr   = ram_addr_q;
  assign ram_byteen = ram_byteen_q;
  assign ram_wrdata = ram_wrdata_q;
  assign ram_wren   = ram_wren_q;
  assign ram_rden   = 1'b0;

endmodule

// File: tb/tb_serial_loader.sv
// Testbench for serial_loader: randomized and directed frames checked against
// a byte-level reference model of the loader protocol.

`ifndef PPC_LOAD
`define PPC_LOAD 2'd1
`endif
`ifndef PPC_EXEC
`define PPC_EXEC 2'd2
`endif
`ifndef PPC_FAIL
`define PPC_FAIL 2'd3
`endif

module tb_serial_loader;

  localparam int AB   = 9;
  localparam int BASE = 4;
  localparam int TO   = 100;
  localparam int CAP  = 4 * ((1 << AB) - BASE);
`ifdef SERIAL_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic [1:0]    next_state;
  logic [5:0]    leds;
  logic [AB-1:0] ram_addr;
  logic [3:0]    ram_byteen;
  logic [31:0]   ram_wrdata;
  logic          ram_rden;
  logic          ram_wren;

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_q[$];
  logic [7:0] pl_q[$];
  wr_t        exp_wr[$];
  wr_t        got_wr[$];
  logic [1:0] exp_ns;
  logic [5:0] exp_leds;

  serial_loader #(
    .ADDR_BITS(AB),
    .BASE_ADDR(BASE),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .next_state(next_state),
    .leds(leds),
    .ram_addr(ram_addr),
    .ram_byteen(ram_byteen),
    .ram_wrdata(ram_wrdata),
    .ram_rden(ram_rden),
    .ram_wren(ram_wren)
  );

  always #5 clk = ~clk;

  // Log every cycle in which a RAM write strobe is visible.
  always @(negedge clk) begin
    if (!rst && ram_wren) got_wr.push_back({ram_addr, ram_wrdata, ram_byteen});
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got_wr.delete();
  endtask

  // Drive tx_q with optional random idle gaps (max_gap = 0 means one byte per cycle).
  task automatic send_stream(input int max_gap);
    int gap;
    for (int i = 0; i < tx_q.size(); i++) begin
      @(negedge clk);
      rx_ready = 1'b1;
      rx_data  = tx_q[i];
      gap = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        rx_ready = 1'b0;
      end
    end
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'd0;
  endtask

  // Reference model: frame bytes, expected writes and final status from pl_q.
  task automatic build_frame(input bit bad_sum);
    logic [31:0] n;
    logic [7:0]  sum;
    wr_t         w;
    bit          fail;
    n = pl_q.size();
    sum = 8'd0;
    tx_q.delete();
    exp_wr.delete();
    tx_q.push_back(n[31:24]);
    tx_q.push_back(n[23:16]);
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
    foreach (pl_q[k]) begin
      tx_q.push_back(pl_q[k]);
      sum = sum + pl_q[k];
    end
    if (CSUM) tx_q.push_back(bad_sum ? (sum ^ 8'h01) : sum);
    for (int wi = 0; wi * 4 < int'(n); wi++) begin
      w = '0;
      w.addr = AB'(BASE + wi);
      for (int j = 0; j < 4; j++) begin
        if (wi * 4 + j < int'(n)) begin
          w.data[31 - 8*j -: 8] = pl_q[wi*4 + j];
          w.be[3 - j] = 1'b1;
        end
      end
      exp_wr.push_back(w);
    end
    fail = CSUM && bad_sum;
    exp_ns   = fail ? `PPC_FAIL : `PPC_EXEC;
    exp_leds = {fail, !fail, n[13:10]};
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (next_state !== `PPC_LOAD) begin failures++; $display("[TB] FAIL reset_next_state got=%0d exp=%0d", next_state, `PPC_LOAD); end
    checks++; if (leds !== 6'd0) begin failures++; $display("[TB] FAIL reset_leds got=%b exp=0", leds); end
    checks++; if (ram_addr !== '0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=0", ram_addr); end
    checks++; if (ram_byteen !== 4'd0) begin failures++; $display("[TB] FAIL reset_byteen got=%b exp=0", ram_byteen); end
    checks++; if (ram_wrdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_wrdata got=%h exp=0", ram_wrdata); end
    checks++; if (ram_wren !== 1'b0) begin failures++; $display("[TB] FAIL reset_wren got=%b exp=0", ram_wren); end
    checks++; if (ram_rden !== 1'b0) begin failures++; $display("[TB] FAIL reset_rden got=%b exp=0", ram_rden); end
    rst = 1'b0;
    got_wr.delete();
  endtask

  task automatic test_spec_frame(input bit bad_sum, input string name);
    apply_reset();
    pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    build_frame(bad_sum);
    send_stream(2);
    repeat (3) @(negedge clk);
    checks++; if (got_wr.size() !== 2) begin failures++; $display("[TB] FAIL %s_write_count got=%0d exp=2", name, got_wr.size()); end
    for (int i = 0; i < 2 && i < got_wr.size(); i++) begin
      checks++; if (got_wr[i] !== exp_wr[i]) begin failures++; $display("[TB] FAIL %s_write%0d got=%h exp=%h", name, i, got_wr[i], exp_wr[i]); end
    end
    checks++; if (got_wr.size() > 0 && got_wr[0].data !== 32'h11223344) begin failures++; $display("[TB] FAIL %s_word0 got=%h exp=11223344", name, got_wr[0].data); end
    checks++; if (next_state !== exp_ns) begin failures++; $display("[TB] FAIL %s_next_state got=%0d exp=%0d", name, next_state, exp_ns); end
    checks++; if (leds !== exp_leds) begin failures++; $display("[TB] FAIL %s_leds got=%b exp=%b", name, leds, exp_leds); end
  endtask

  task automatic test_overflow();
    logic [31:0] lens[3];
    lens[0] = 32'hFFFF_FFFF;
    lens[1] = CAP + 1;
    lens[2] = CAP;
    for (int t = 0; t < 3; t++) begin
      apply_reset();
      tx_q = '{lens[t][31:24], lens[t][23:16], lens[t][15:8], lens[t][7:0]};
      send_stream(0);
      exp_ns = (t == 2) ? `PPC_LOAD : `PPC_FAIL;
      checks++; if (next_state !== exp_ns) begin failures++; $display("[TB] FAIL overflow%0d_next_state got=%0d exp=%0d", t, next_state, exp_ns); end
      exp_leds = (t == 2) ? 6'b000000 : 6'b100000;
      checks++; if (leds !== exp_leds) begin failures++; $display("[TB] FAIL overflow%0d_leds got=%b exp=%b", t, leds, exp_leds); end
      repeat (2) @(negedge clk);
      checks++; if (got_wr.size() !== 0) begin failures++; $display("[TB] FAIL overflow%0d_writes got=%0d exp=0", t, got_wr.size()); end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03};
    send_stream(0);
    repeat (99) @(negedge clk);
    checks++; if (next_state !== `PPC_LOAD) begin failures++; $display("[TB] FAIL timeout_early got=%0d exp=%0d", next_state, `PPC_LOAD); end
    @(negedge clk);
    checks++; if (next_state !== `PPC_FAIL) begin failures++; $display("[TB] FAIL timeout_expire got=%0d exp=%0d", next_state, `PPC_FAIL); end
    checks++; if (leds !== 6'b100000) begin failures++; $display("[TB] FAIL timeout_leds got=%b exp=100000", leds); end
    checks++; if (got_wr.size() !== 0) begin failures++; $display("[TB] FAIL timeout_writes got=%0d exp=0", got_wr.size()); end
  endtask

  task automatic test_midframe_reset();
    apply_reset();
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_stream(0);
    @(negedge clk);
    checks++; if (got_wr.size() !== 1) begin failures++; $display("[TB] FAIL midreset_pre_writes got=%0d exp=1", got_wr.size()); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ram_wren !== 1'b0 || leds !== 6'd0 || ram_addr !== '0) begin failures++; $display("[TB] FAIL midreset_async got=%b/%b/%h exp=0/0/0", ram_wren, leds, ram_addr); end
    @(negedge clk);
    rst = 1'b0;
    got_wr.delete();
    pl_q = '{8'hAA, 8'hBB};
    build_frame(1'b0);
    send_stream(0);
    repeat (3) @(negedge clk);
    checks++; if (got_wr.size() !== 1) begin failures++; $display("[TB] FAIL midreset_write_count got=%0d exp=1", got_wr.size()); end
    checks++; if (got_wr.size() > 0 && got_wr[0] !== exp_wr[0]) begin failures++; $display("[TB] FAIL midreset_write got=%h exp=%h", got_wr[0], exp_wr[0]); end
    checks++; if (got_wr.size() > 0 && got_wr[0].data !== 32'hAABB0000) begin failures++; $display("[TB] FAIL midreset_data got=%h exp=aabb0000", got_wr[0].data); end
    checks++; if (next_state !== `PPC_EXEC) begin failures++; $display("[TB] FAIL midreset_next_state got=%0d exp=%0d", next_state, `PPC_EXEC); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build_frame(1'b0);
    send_stream(0);
    repeat (2) @(negedge clk);
    checks++; if (got_wr.size() !== 1) begin failures++; $display("[TB] FAIL b2b_write_count got=%0d exp=1", got_wr.size()); end
    checks++; if (got_wr.size() > 0 && got_wr[0] !== {AB'(BASE), 32'hDEADBEEF, 4'b1111}) begin failures++; $display("[TB] FAIL b2b_write got=%h exp=%h", got_wr[0], {AB'(BASE), 32'hDEADBEEF, 4'b1111}); end
    checks++; if (next_state !== `PPC_EXEC) begin failures++; $display("[TB] FAIL b2b_next_state got=%0d exp=%0d", next_state, `PPC_EXEC); end
    // DONE is terminal: further bytes must be ignored.
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stream(0);
    repeat (2) @(negedge clk);
    checks++; if (got_wr.size() !== 1) begin failures++; $display("[TB] FAIL terminal_writes got=%0d exp=1", got_wr.size()); end
    checks++; if (next_state !== `PPC_EXEC) begin failures++; $display("[TB] FAIL terminal_state got=%0d exp=%0d", next_state, `PPC_EXEC); end
  endtask

  task automatic test_random();
    int n;
    bit bad;
    for (int f = 0; f < 10; f++) begin
      apply_reset();
      n = (f == 0) ? 0 : int'($urandom_range(23, 1));
      bad = ($urandom_range(3, 0) == 0);
      pl_q.delete();
      for (int k = 0; k < n; k++) pl_q.push_back(8'($urandom));
      build_frame(bad);
      send_stream(3);
      repeat (3) @(negedge clk);
      checks++; if (got_wr.size() !== exp_wr.size()) begin failures++; $display("[TB] FAIL rand%0d_write_count got=%0d exp=%0d", f, got_wr.size(), exp_wr.size()); end
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
        checks++; if (got_wr[i] !== exp_wr[i]) begin failures++; $display("[TB] FAIL rand%0d_write%0d got=%h exp=%h", f, i, got_wr[i], exp_wr[i]); end
      end
      checks++; if (next_state !== exp_ns) begin failures++; $display("[TB] FAIL rand%0d_next_state got=%0d exp=%0d", f, next_state, exp_ns); end
      checks++; if (leds !== exp_leds) begin failures++; $display("[TB] FAIL rand%0d_leds got=%b exp=%b", f, leds, exp_leds); end
    end
  endtask

  task automatic test_leds_progress();
    int errs;
    apply_reset();
    pl_q.delete();
    for (int k = 0; k < 1100; k++) pl_q.push_back(8'($urandom));
    build_frame(1'b0);
    send_stream(0);
    repeat (2) @(negedge clk);
    checks++; if (got_wr.size() !== exp_wr.size()) begin failures++; $display("[TB] FAIL progress_write_count got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    errs = 0;
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) if (got_wr[i] !== exp_wr[i]) errs++;
    checks++; if (errs !== 0) begin failures++; $display("[TB] FAIL progress_write_data got=%0d bad words exp=0", errs); end
    checks++; if (leds !== exp_leds) begin failures++; $display("[TB] FAIL progress_leds got=%b exp=%b", leds, exp_leds); end
    checks++; if (next_state !== `PPC_EXEC) begin failures++; $display("[TB] FAIL progress_next_state got=%0d exp=%0d", next_state, `PPC_EXEC); end
  endtask

  initial begin
    test_reset();
    test_spec_frame(1'b0, "spec_good");
    if (CSUM) test_spec_frame(1'b1, "spec_badsum");
    test_overflow();
    test_timeout();
    test_midframe_reset();
    test_back_to_back();
    test_random();
    test_leds_progress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
